usb_line_encoder: RTL and testbench

Serial line-side stage placed directly downstream of the packet bitstream encoder. It takes the encoder's serial bit (`outb`) and packet-active flag (`sending`), and does three things: inserts USB stuff bits, NRZI-encodes the stream, and appends the SE0/J end-of-packet. The result drives the differential line pair `dp`/`dm`. It throttles the encoder through `pause` whenever it cannot accept a data bit.

---
 rtl/usb_line_if.sv | 22 ++
 rtl/usb_line_encoder.sv | 111 +++++++++++
 tb/tb_usb_line_encoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/usb_line_if.sv
// Bit-stream and line-side signals between the packet encoder and usb_line_encoder.
// A data bit transfers on a rising clk edge where in_valid=1 and pause=0; otherwise the encoder holds in_bit.
interface usb_line_if;
  logic       in_bit;
  logic       in_valid;
  logic       pause;
  logic       dp;
  logic       dm;
  logic       line_busy;
  logic       eop_done;
  logic [1:0] dbg_state;

  modport master (
    output in_bit, in_valid,
    input  pause, dp, dm, line_busy, eop_done, dbg_state
  );

  modport slave (
    input  in_bit, in_valid,
    output pause, dp, dm, line_busy, eop_done, dbg_state
  );
endinterface

// File: rtl/usb_line_encoder.sv
// USB line stage: bit stuffing, NRZI encoding and SE0/J end-of-packet generation.
// dp/dm are registered; pause, line_busy and eop_done are combinational from state.
module usb_line_encoder #(
    parameter int SE0_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_L,
    usb_line_if.slave  line
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2,
        EOP   = 2'd3
    } state_t;

    localparam logic [3:0] SE0_LEN_C = 4'(SE0_LEN);

    state_t     state, state_n;
    logic       lvl, lvl_n;
    logic [2:0] ones, ones_n;
    logic [3:0] se0_cnt, se0_cnt_n;
    logic       dp_q, dm_q, dp_n, dm_n;
    logic       pause_c, eop_done_c;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= IDLE;
            lvl     <= 1'b1;
            ones    <= 3'd0;
            se0_cnt <= 4'd0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            state   <= state_n;
            lvl     <= lvl_n;
            ones    <= ones_n;
            se0_cnt <= se0_cnt_n;
            dp_q    <= dp_n;
            dm_q    <= dm_n;
        end
    end

    always_comb begin
        state_n    = state;
        lvl_n      = lvl;
        ones_n     = ones;
        se0_cnt_n  = se0_cnt;
        dp_n       = dp_q;
        dm_n       = dm_q;
        pause_c    = 1'b0;
        eop_done_c = 1'b0;

        case (state)
            IDLE, DATA: begin
                if (line.in_valid) begin
                    // NRZI: a 0 toggles the level, a 1 holds it
                    lvl_n   = line.in_bit ? lvl : ~lvl;
                    dp_n    = lvl_n;
                    dm_n    = ~lvl_n;
                    ones_n  = line.in_bit ? ones + 3'd1 : 3'd0;
                    state_n = (line.in_bit && ones == 3'd5) ? STUFF : DATA;
                end else if (state == IDLE) begin
                    dp_n   = 1'b1;
                    dm_n   = 1'b0;
                    ones_n = 3'd0;
                end else begin
                    dp_n      = 1'b0;
                    dm_n      = 1'b0;
                    ones_n    = 3'd0;
                    se0_cnt_n = 4'd1;
                    state_n   = EOP;
                end
            end
            STUFF: begin
                pause_c = 1'b1;
                lvl_n   = ~lvl;
                dp_n    = ~lvl;
                dm_n    = lvl;
                ones_n  = 3'd0;
                state_n = DATA;
            end
            EOP: begin
                // A new packet's first bit waits here until the line is back in J
                pause_c = line.in_valid;
                if (se0_cnt < SE0_LEN_C) begin
                    dp_n      = 1'b0;
                    dm_n      = 1'b0;
                    se0_cnt_n = se0_cnt + 4'd1;
                end else begin
                    dp_n       = 1'b1;
                    dm_n       = 1'b0;
                    lvl_n      = 1'b1;
                    se0_cnt_n  = 4'd0;
                    eop_done_c = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign line.pause     = pause_c;
    assign line.eop_done  = eop_done_c;
    assign line.line_busy = (state != IDLE);
    assign line.dp        = dp_q;
    assign line.dm        = dm_q;
    assign line.dbg_state = state;

endmodule

// File: tb/tb_usb_line_encoder.sv
// Directed bench for usb_line_encoder: default SE0_LEN=2 instance plus an SE0_LEN=1 instance.
module tb_usb_line_encoder;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk;
  logic rst_L;
  int   checks;
  int   failures;

  usb_line_if bus0 ();
  usb_line_if bus1 ();

  usb_line_encoder #(.SE0_LEN(2)) dut0 (.clk(clk), .rst_L(rst_L), .line(bus0.slave));
  usb_line_encoder #(.SE0_LEN(1)) dut1 (.clk(clk), .rst_L(rst_L), .line(bus1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One cycle on the selected instance: drive inputs, check combinational
  // outputs, then check the line value loaded at the rising edge.
  task automatic step(input bit sel, input logic b, input logic v,
                      input logic exp_pause, input logic exp_eop,
                      input logic exp_busy, input logic [1:0] exp_line,
                      input string tag);
    logic [1:0] ln;
    if (sel) begin
      bus1.in_bit = b; bus1.in_valid = v;
    end else begin
      bus0.in_bit = b; bus0.in_valid = v;
    end
    #1;
    check({tag, ".pause"}, {7'd0, sel ? bus1.pause     : bus0.pause},     {7'd0, exp_pause});
    check({tag, ".eop"},   {7'd0, sel ? bus1.eop_done  : bus0.eop_done},  {7'd0, exp_eop});
    check({tag, ".busy"},  {7'd0, sel ? bus1.line_busy : bus0.line_busy}, {7'd0, exp_busy});
    @(posedge clk);
    #1;
    ln = sel ? {bus1.dp, bus1.dm} : {bus0.dp, bus0.dm};
    check({tag, ".line"}, {6'd0, ln}, {6'd0, exp_line});
  endtask

  // Closes a packet on dut0 from DATA: SE0, SE0, J, then idle J.
  task automatic eop0(input string tag);
    step(0, 0, 0, 0, 0, 1, SE0, {tag, ".e0"});
    step(0, 0, 0, 0, 0, 1, SE0, {tag, ".e1"});
    step(0, 0, 0, 0, 1, 1, J,   {tag, ".e2"});
    step(0, 0, 0, 0, 0, 0, J,   {tag, ".idle"});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus0.in_bit = 0; bus0.in_valid = 0;
    bus1.in_bit = 0; bus1.in_valid = 0;
    rst_L = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.line",  {6'd0, bus0.dp, bus0.dm}, {6'd0, J});
    check("rst.pause", {7'd0, bus0.pause},       8'd0);
    check("rst.busy",  {7'd0, bus0.line_busy},   8'd0);
    check("rst.eop",   {7'd0, bus0.eop_done},    8'd0);
    check("rst.state", {6'd0, bus0.dbg_state},   8'd0);
    rst_L = 1;
    step(0, 0, 0, 0, 0, 0, J, "idle");

    // 0000000 1: every 0 toggles, the final 1 holds
    step(0, 0, 1, 0, 0, 0, K, "nrzi0");
    step(0, 0, 1, 0, 0, 1, J, "nrzi1");
    step(0, 0, 1, 0, 0, 1, K, "nrzi2");
    step(0, 0, 1, 0, 0, 1, J, "nrzi3");
    step(0, 0, 1, 0, 0, 1, K, "nrzi4");
    step(0, 0, 1, 0, 0, 1, J, "nrzi5");
    step(0, 0, 1, 0, 0, 1, K, "nrzi6");
    step(0, 1, 1, 0, 0, 1, K, "nrzi7");
    eop0("nrzi");

    // Eight 1s from J: stuff after the sixth, none after the eighth
    step(0, 1, 1, 0, 0, 0, J, "ones0");
    for (int i = 1; i < 6; i++) step(0, 1, 1, 0, 0, 1, J, $sformatf("ones%0d", i));
    check("ones.state", {6'd0, bus0.dbg_state}, 8'd2);
    step(0, 1, 1, 1, 0, 1, K, "stuff");
    step(0, 1, 1, 0, 0, 1, K, "ones6");
    step(0, 1, 1, 0, 0, 1, K, "ones7");
    eop0("ones");

    // Packet ending in six 1s: stuff bit precedes the EOP
    step(0, 0, 1, 0, 0, 0, K, "tail0");
    for (int i = 1; i < 7; i++) step(0, 1, 1, 0, 0, 1, K, $sformatf("tail%0d", i));
    step(0, 0, 0, 1, 0, 1, J, "tailstuff");
    eop0("tail");

    // New packet raised during EOP with in_bit=0: held until J shown once
    step(0, 1, 1, 0, 0, 0, J,   "rv0");
    step(0, 0, 0, 0, 0, 1, SE0, "rv.e0");
    step(0, 0, 1, 1, 0, 1, SE0, "rv.e1");
    step(0, 0, 1, 1, 1, 1, J,   "rv.e2");
    step(0, 0, 1, 0, 0, 0, K,   "rv.first");
    eop0("rv");

    // Reset while in STUFF with the line at K
    step(0, 0, 1, 0, 0, 0, K, "ar0");
    for (int i = 1; i < 7; i++) step(0, 1, 1, 0, 0, 1, K, $sformatf("ar%0d", i));
    bus0.in_bit = 1; bus0.in_valid = 1;
    #1;
    check("ar.pre_pause", {7'd0, bus0.pause}, 8'd1);
    rst_L = 0;
    #1;
    check("ar.line",  {6'd0, bus0.dp, bus0.dm}, {6'd0, J});
    check("ar.pause", {7'd0, bus0.pause},       8'd0);
    check("ar.busy",  {7'd0, bus0.line_busy},   8'd0);
    bus0.in_valid = 0;
    @(posedge clk);
    #1;
    rst_L = 1;
    step(0, 0, 1, 0, 0, 0, K, "ar.post0");
    step(0, 1, 1, 0, 0, 1, K, "ar.post1");
    eop0("ar");

    // SE0_LEN=1 instance: one SE0 then J, eop_done in the first EOP cycle
    step(1, 0, 1, 0, 0, 0, K,   "s1.b0");
    step(1, 1, 1, 0, 0, 1, K,   "s1.b1");
    step(1, 0, 0, 0, 0, 1, SE0, "s1.e0");
    step(1, 0, 0, 0, 1, 1, J,   "s1.e1");
    step(1, 0, 0, 0, 0, 0, J,   "s1.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
